wheel_speed_calculator: RTL and testbench

Inverse-kinematics engine for the four-wheel mecanum base: converts a commanded robot-frame velocity (vx, vy, omega) into four wheel angular-speed setpoints W1..W4. It is the counterpart of the odometry calculator, which maps measured wheel speeds to pose. Its outputs feed the per-wheel PID speed controllers. It uses a single shared multiplier sequenced by an FSM, with a start/busy/done handshake.

---
 rtl/wheel_speed_calculator_if.sv | 42 ++++
 rtl/wheel_speed_calculator.sv | 155 +++++++++++++++
 tb/tb_wheel_speed_calculator.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/wheel_speed_calculator_if.sv
// Command/result bundle between the motion planner and the wheel speed calculator.
// The master issues (vx, vy, omega) with START and reads back BUSY, DONE and W1..W4.
interface wheel_speed_calculator_if #(
    parameter int unsigned DATAWIDTH_N = 32
);
    logic                          WHEEL_SPEED_CALCULATOR_START_InHigh;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_VX_InBus;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_VY_InBus;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_OMEGA_InBus;
    logic                          WHEEL_SPEED_CALCULATOR_BUSY_OutLow;
    logic                          WHEEL_SPEED_CALCULATOR_DONE_OutHigh;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_W1_OutBus;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_W2_OutBus;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_W3_OutBus;
    logic signed [DATAWIDTH_N-1:0] WHEEL_SPEED_CALCULATOR_W4_OutBus;

    modport master (
        output WHEEL_SPEED_CALCULATOR_START_InHigh,
        output WHEEL_SPEED_CALCULATOR_VX_InBus,
        output WHEEL_SPEED_CALCULATOR_VY_InBus,
        output WHEEL_SPEED_CALCULATOR_OMEGA_InBus,
        input  WHEEL_SPEED_CALCULATOR_BUSY_OutLow,
        input  WHEEL_SPEED_CALCULATOR_DONE_OutHigh,
        input  WHEEL_SPEED_CALCULATOR_W1_OutBus,
        input  WHEEL_SPEED_CALCULATOR_W2_OutBus,
        input  WHEEL_SPEED_CALCULATOR_W3_OutBus,
        input  WHEEL_SPEED_CALCULATOR_W4_OutBus
    );

    modport slave (
        input  WHEEL_SPEED_CALCULATOR_START_InHigh,
        input  WHEEL_SPEED_CALCULATOR_VX_InBus,
        input  WHEEL_SPEED_CALCULATOR_VY_InBus,
        input  WHEEL_SPEED_CALCULATOR_OMEGA_InBus,
        output WHEEL_SPEED_CALCULATOR_BUSY_OutLow,
        output WHEEL_SPEED_CALCULATOR_DONE_OutHigh,
        output WHEEL_SPEED_CALCULATOR_W1_OutBus,
        output WHEEL_SPEED_CALCULATOR_W2_OutBus,
        output WHEEL_SPEED_CALCULATOR_W3_OutBus,
        output WHEEL_SPEED_CALCULATOR_W4_OutBus
    );
endinterface

// File: rtl/wheel_speed_calculator.sv
// Mecanum inverse kinematics: (vx, vy, omega) -> four wheel speed setpoints,
// sequenced over one shared saturating Q-format multiplier.
module wheel_speed_calculator #(
    parameter int unsigned DATAWIDTH_N  = 32,
    parameter int unsigned FRACTIONAL_Q = 15,
    parameter int          K_LXLY       = 9830,
    parameter int          INV_R        = 655360
) (
    input logic                    WHEEL_SPEED_CALCULATOR_CLOCK_50,
    input logic                    WHEEL_SPEED_CALCULATOR_Reset_InLow,
    wheel_speed_calculator_if.slave bus
);
    localparam int unsigned SUM_W  = DATAWIDTH_N + 2;
    localparam int unsigned PROD_W = 2 * DATAWIDTH_N;

    typedef logic signed [DATAWIDTH_N-1:0] data_t;
    typedef logic signed [SUM_W-1:0]       sum_t;

    localparam data_t K_C     = DATAWIDTH_N'(K_LXLY);
    localparam data_t INV_R_C = DATAWIDTH_N'(INV_R);
    localparam data_t D_MAX   = {1'b0, {(DATAWIDTH_N-1){1'b1}}};
    localparam data_t D_MIN   = {1'b1, {(DATAWIDTH_N-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_MULK, ST_SUM, ST_SC1, ST_SC2, ST_SC3, ST_SC4, ST_DONE
    } state_t;

    state_t state_q;
    data_t  vx_q, vy_q, om_q, k_q;
    data_t  s_q     [4];
    data_t  stage_q [3];
    data_t  w_q     [4];
    logic   busy_q, done_q;

    function automatic sum_t sx(input data_t v);
        return {{2{v[DATAWIDTH_N-1]}}, v};
    endfunction

    function automatic data_t sat_sum(input sum_t x);
        if (&x[SUM_W-1:DATAWIDTH_N-1] || ~|x[SUM_W-1:DATAWIDTH_N-1])
            return x[DATAWIDTH_N-1:0];
        return x[SUM_W-1] ? D_MIN : D_MAX;
    endfunction

    // Shared multiplier: operand selection follows the sequencer state
    data_t                     mul_a, mul_b, mul_sat;
    logic signed [PROD_W-1:0]  mul_a_x, mul_b_x, mul_full, mul_shr;

    always_comb begin
        mul_a = s_q[0];
        mul_b = INV_R_C;
        case (state_q)
            ST_MULK: begin
                mul_a = K_C;
                mul_b = om_q;
            end
            ST_SC2:  mul_a = s_q[1];
            ST_SC3:  mul_a = s_q[2];
            ST_SC4:  mul_a = s_q[3];
            default: ;
        endcase
        mul_a_x  = {{DATAWIDTH_N{mul_a[DATAWIDTH_N-1]}}, mul_a};
        mul_b_x  = {{DATAWIDTH_N{mul_b[DATAWIDTH_N-1]}}, mul_b};
        mul_full = mul_a_x * mul_b_x;
        mul_shr  = mul_full >>> FRACTIONAL_Q;
        if (&mul_shr[PROD_W-1:DATAWIDTH_N-1] || ~|mul_shr[PROD_W-1:DATAWIDTH_N-1])
            mul_sat = mul_shr[DATAWIDTH_N-1:0];
        else
            mul_sat = mul_shr[PROD_W-1] ? D_MIN : D_MAX;
    end

    sum_t  vx_x, vy_x, k_x;
    data_t sum_sat [4];

    always_comb begin
        vx_x       = sx(vx_q);
        vy_x       = sx(vy_q);
        k_x        = sx(k_q);
        sum_sat[0] = sat_sum(vx_x - vy_x - k_x);
        sum_sat[1] = sat_sum(vx_x + vy_x + k_x);
        sum_sat[2] = sat_sum(vx_x + vy_x - k_x);
        sum_sat[3] = sat_sum(vx_x - vy_x + k_x);
    end

    // Sequencer; W outputs and DONE are loaded on entry to ST_DONE so they
    // become visible in the same cycle the FSM reports completion.
    always_ff @(posedge WHEEL_SPEED_CALCULATOR_CLOCK_50 or negedge WHEEL_SPEED_CALCULATOR_Reset_InLow) begin
        if (!WHEEL_SPEED_CALCULATOR_Reset_InLow) begin
            state_q <= ST_IDLE;
            vx_q    <= '0;
            vy_q    <= '0;
            om_q    <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_q[i] <= '0;
                w_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) stage_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.WHEEL_SPEED_CALCULATOR_START_InHigh) begin
                        vx_q    <= bus.WHEEL_SPEED_CALCULATOR_VX_InBus;
                        vy_q    <= bus.WHEEL_SPEED_CALCULATOR_VY_InBus;
                        om_q    <= bus.WHEEL_SPEED_CALCULATOR_OMEGA_InBus;
                        busy_q  <= 1'b0;
                        state_q <= ST_MULK;
                    end
                end
                ST_MULK: begin
                    k_q     <= mul_sat;
                    state_q <= ST_SUM;
                end
                ST_SUM: begin
                    for (int i = 0; i < 4; i++) s_q[i] <= sum_sat[i];
                    state_q <= ST_SC1;
                end
                ST_SC1: begin
                    stage_q[0] <= mul_sat;
                    state_q    <= ST_SC2;
                end
                ST_SC2: begin
                    stage_q[1] <= mul_sat;
                    state_q    <= ST_SC3;
                end
                ST_SC3: begin
                    stage_q[2] <= mul_sat;
                    state_q    <= ST_SC4;
                end
                ST_SC4: begin
                    w_q[0]  <= stage_q[0];
                    w_q[1]  <= stage_q[1];
                    w_q[2]  <= stage_q[2];
                    w_q[3]  <= mul_sat;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.WHEEL_SPEED_CALCULATOR_BUSY_OutLow  = busy_q;
    assign bus.WHEEL_SPEED_CALCULATOR_DONE_OutHigh = done_q;
    assign bus.WHEEL_SPEED_CALCULATOR_W1_OutBus    = w_q[0];
    assign bus.WHEEL_SPEED_CALCULATOR_W2_OutBus    = w_q[1];
    assign bus.WHEEL_SPEED_CALCULATOR_W3_OutBus    = w_q[2];
    assign bus.WHEEL_SPEED_CALCULATOR_W4_OutBus    = w_q[3];
endmodule

// File: tb/tb_wheel_speed_calculator.sv
// Scoreboard bench for wheel_speed_calculator: directed cases, handshake timing,
// reset behaviour and randomized commands against an integer-arithmetic model.
module tb_wheel_speed_calculator;
    logic clk;
    logic rst_n;

    wheel_speed_calculator_if bus();

    wheel_speed_calculator dut (
        .WHEEL_SPEED_CALCULATOR_CLOCK_50    (clk),
        .WHEEL_SPEED_CALCULATOR_Reset_InLow (rst_n),
        .bus                                (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [31:0] w1, w2, w3, w4;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic        busy, done;
    logic [31:0] w1, w2, w3, w4;
    assign busy = bus.WHEEL_SPEED_CALCULATOR_BUSY_OutLow;
    assign done = bus.WHEEL_SPEED_CALCULATOR_DONE_OutHigh;
    assign w1   = bus.WHEEL_SPEED_CALCULATOR_W1_OutBus;
    assign w2   = bus.WHEEL_SPEED_CALCULATOR_W2_OutBus;
    assign w3   = bus.WHEEL_SPEED_CALCULATOR_W3_OutBus;
    assign w4   = bus.WHEEL_SPEED_CALCULATOR_W4_OutBus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on real-valued meaning
    function automatic longint sat32(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return sat32((a * b) >>> 15);
    endfunction

    function automatic exp_t model(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] om);
        longint x, y, k;
        exp_t   e;
        x    = longint'($signed(vx));
        y    = longint'($signed(vy));
        k    = qmul(9830, longint'($signed(om)));
        e.w1 = 32'(qmul(sat32(x - y - k), 655360));
        e.w2 = 32'(qmul(sat32(x + y + k), 655360));
        e.w3 = 32'(qmul(sat32(x + y - k), 655360));
        e.w4 = 32'(qmul(sat32(x - y + k), 655360));
        return e;
    endfunction

    // Monitor: every DONE pulse pops one expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("W1", w1, e.w1);
                chk("W2", w2, e.w2);
                chk("W3", w3, e.w3);
                chk("W4", w4, e.w4);
            end
        end
    end

    task automatic drive(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] om, input logic st);
        bus.WHEEL_SPEED_CALCULATOR_VX_InBus    = vx;
        bus.WHEEL_SPEED_CALCULATOR_VY_InBus    = vy;
        bus.WHEEL_SPEED_CALCULATOR_OMEGA_InBus = om;
        bus.WHEEL_SPEED_CALCULATOR_START_InHigh = st;
    endtask

    // One START pulse; checks the 7-cycle latency and BUSY returning high after DONE
    task automatic run_txn(input logic [31:0] vx, input logic [31:0] vy, input logic [31:0] om);
        int n;
        @(negedge clk);
        drive(vx, vy, om, 1'b1);
        sb.push_back(model(vx, vy, om));
        @(negedge clk);
        bus.WHEEL_SPEED_CALCULATOR_START_InHigh = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd7);
        chk("busy_during", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("busy_after", {31'd0, busy}, 32'd1);
        chk("done_after", {31'd0, done}, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'(int'($urandom_range(0, 262144)) - 131072);
            1:       return 32'($urandom);
            2:       return ($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'h80000000;
            default: return 32'(int'($urandom_range(0, 8192)) - 4096);
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int dcnt, first_n, second_n;
        rst_n = 1'b0;
        drive(32'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_w1", w1, 32'd0);
        chk("rst_w4", w4, 32'd0);
        rst_n = 1'b1;

        run_txn(32'h00008000, 32'h0, 32'h0);
        chk("vx_w1_const", w1, 32'h000A0000);
        run_txn(32'h0, 32'h00008000, 32'h0);
        chk("vy_w1_const", w1, 32'hFFF60000);
        chk("vy_w2_const", w2, 32'h000A0000);
        run_txn(32'h0, 32'h0, 32'h00008000);
        chk("om_w2_const", w2, 32'h0002FFF8);
        chk("om_w3_const", w3, 32'hFFFD0008);
        run_txn(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0);
        chk("satp_w2_const", w2, 32'h7FFFFFFF);
        chk("satp_w1_const", w1, 32'h00000000);
        run_txn(32'h80000000, 32'h80000000, 32'h0);
        chk("satn_w3_const", w3, 32'h80000000);

        // START ignored while busy and in DONE; inputs changed mid-run
        @(negedge clk);
        drive(32'h00010000, 32'h00004000, 32'hFFFF8000, 1'b1);
        sb.push_back(model(32'h00010000, 32'h00004000, 32'hFFFF8000));
        dcnt = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dcnt++;
                chk("ignore_done_cycle", 32'(n), 32'd7);
            end
            if (n == 3 || n == 7) drive(32'h00123456, 32'h7FFF0000, 32'h00003000, 1'b1);
            else bus.WHEEL_SPEED_CALCULATOR_START_InHigh = 1'b0;
            if (n == 8) chk("ignore_busy_t8", {31'd0, busy}, 32'd1);
        end
        chk("ignore_done_count", 32'(dcnt), 32'd1);

        // START held high: accepted again 8 cycles after the first acceptance
        @(negedge clk);
        drive(32'h00004000, 32'hFFFFC000, 32'h00002000, 1'b1);
        sb.push_back(model(32'h00004000, 32'hFFFFC000, 32'h00002000));
        sb.push_back(model(32'hFFFE0000, 32'h00030000, 32'hFFFF0000));
        first_n = 0;
        second_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (first_n == 0) first_n = n;
                else second_n = n;
            end
            if (n == 1) drive(32'hFFFE0000, 32'h00030000, 32'hFFFF0000, 1'b1);
            if (n == 9) bus.WHEEL_SPEED_CALCULATOR_START_InHigh = 1'b0;
        end
        chk("b2b_first", 32'(first_n), 32'd7);
        chk("b2b_second", 32'(second_n), 32'd15);

        // Asynchronous reset during SC2 discards the run
        @(negedge clk);
        drive(32'h00008000, 32'h0, 32'h0, 1'b1);
        sb.push_back(model(32'h00008000, 32'h0, 32'h0));
        @(negedge clk);
        bus.WHEEL_SPEED_CALCULATOR_START_InHigh = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mrst_w1", w1, 32'd0);
        chk("mrst_w2", w2, 32'd0);
        chk("mrst_w3", w3, 32'd0);
        chk("mrst_w4", w4, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(32'h00008000, 32'h0, 32'h0);
        chk("post_rst_w3_const", w3, 32'h000A0000);

        for (int i = 0; i < 24; i++) run_txn(rnd_val(), rnd_val(), rnd_val());

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
